// File: rtl/fast_window_scheduler_if.sv
// Handshake bundle between the Gaussian producer / FAST engine side (master)
// and the window scheduler (slave). The perf counter outputs exist only when
// FAST_PERF_CNT_EN is defined.
interface fast_window_scheduler_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned HEIGHT = 16
);
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             gaus_sample_flag;
    logic             gaus_done;
    logic             fast_done_flag;
    logic             gaus_stall;
    logic             fast_start;
    logic [ROW_W-1:0] fast_row;
    logic [COL_W-1:0] fast_col;
    logic             frame_done;
    logic             err;
`ifdef FAST_PERF_CNT_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      wait_cycles;
`endif

    modport master (
        output gaus_sample_flag, gaus_done, fast_done_flag,
`ifdef FAST_PERF_CNT_EN
        input  stall_cycles, wait_cycles,
`endif
        input  gaus_stall, fast_start, fast_row, fast_col, frame_done, err
    );

    modport slave (
        input  gaus_sample_flag, gaus_done, fast_done_flag,
`ifdef FAST_PERF_CNT_EN
        output stall_cycles, wait_cycles,
`endif
        output gaus_stall, fast_start, fast_row, fast_col, frame_done, err
    );
endinterface

// File: rtl/fast_window_scheduler.sv
// FAST window scheduler: counts Gaussian samples in raster order, launches one
// FAST window per non-border centre once its whole window has been produced,
// backpressures the producer when the line buffer is full and pulses
// frame_done after the last window. Define FAST_PERF_CNT_EN to add the
// stall_cycles / wait_cycles performance counters.
module fast_window_scheduler #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned HEIGHT = 16,
    parameter int unsigned RADIUS = 3,
    parameter int unsigned DEPTH  = 7
) (
    input logic                  clk,
    input logic                  n_rst,
    fast_window_scheduler_if.slave bus
);
    localparam int unsigned TOTAL = WIDTH * HEIGHT;
    localparam int unsigned PW    = $clog2(TOTAL + 1);
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [PW-1:0]    PROD_MAX  = PW'(TOTAL);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(RADIUS);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1 - RADIUS);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(RADIUS);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1 - RADIUS);

    typedef enum logic [2:0] {IDLE, WAIT, START, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    produced;
    logic             gaus_fin;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             err_q;
    logic [31:0]      need;
    logic [31:0]      stall_base;
    logic             window_ready;
    logic             stall;
    logic             last_window;
    logic             start_pulse;
    logic             done_pulse;

    // Window threshold and line-buffer occupancy limit for the current centre
    always_comb begin
        need       = (32'(row) + 32'(RADIUS)) * 32'(WIDTH) + 32'(col) + 32'(RADIUS) + 32'd1;
        // row never drops below RADIUS, so the subtraction cannot wrap
        stall_base = (32'(row) - 32'(RADIUS)) * 32'(WIDTH) + 32'(DEPTH) * 32'(WIDTH);
        window_ready = (32'(produced) >= need) || gaus_fin;
        stall        = (32'(produced) >= stall_base);
        last_window  = (row == ROW_LAST) && (col == COL_LAST);
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and pulse outputs
    always_comb begin
        state_nxt   = state;
        start_pulse = 1'b0;
        done_pulse  = 1'b0;
        case (state)
            IDLE:  if (bus.gaus_sample_flag) state_nxt = WAIT;
            WAIT:  if (window_ready) state_nxt = START;
            START: begin
                start_pulse = 1'b1;
                state_nxt   = BUSY;
            end
            BUSY:  if (bus.fast_done_flag) state_nxt = last_window ? DONE : WAIT;
            DONE: begin
                done_pulse = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sample counter (saturating) and producer-finished flag; DONE clears both
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            produced <= '0;
            gaus_fin <= 1'b0;
        end else if (state == DONE) begin
            produced <= '0;
            gaus_fin <= 1'b0;
        end else begin
            if (bus.gaus_sample_flag && (produced != PROD_MAX)) produced <= produced + PW'(1);
            if (bus.gaus_done) gaus_fin <= 1'b1;
        end
    end

    // Centre position: raster advance over the non-border region on window done
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row <= ROW_FIRST;
            col <= COL_FIRST;
        end else if (state == DONE) begin
            row <= ROW_FIRST;
            col <= COL_FIRST;
        end else if ((state == BUSY) && bus.fast_done_flag && !last_window) begin
            if (col == COL_LAST) begin
                col <= COL_FIRST;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Sticky protocol error: overflow, sample under stall, stray done
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_q <= 1'b0;
        end else if ((bus.gaus_sample_flag && ((produced == PROD_MAX) || stall)) ||
                     (bus.fast_done_flag && (state != BUSY))) begin
            err_q <= 1'b1;
        end
    end

`ifdef FAST_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] wait_cnt;

    // Saturating perf counters; frozen during DONE, cleared on the way back to IDLE
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt <= '0;
            wait_cnt  <= '0;
        end else if (state == DONE) begin
            stall_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if ((state == WAIT) && (wait_cnt != '1)) wait_cnt <= wait_cnt + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt;
    assign bus.wait_cycles  = wait_cnt;
`endif

    assign bus.gaus_stall = stall;
    assign bus.fast_start = start_pulse;
    assign bus.frame_done = done_pulse;
    assign bus.err        = err_q;
    // Centre is only presented while a window is launched or outstanding
    assign bus.fast_row   = ((state == START) || (state == BUSY)) ? row : '0;
    assign bus.fast_col   = ((state == START) || (state == BUSY)) ? col : '0;
endmodule

// File: tb/tb_fast_window_scheduler.sv
// Scoreboard bench for fast_window_scheduler (8x8 frame, radius 3, depth 7).
// The driver updates a window-list reference model after each clock edge and
// queues expected launches; the monitor compares on the falling edge.
module tb_fast_window_scheduler;
    localparam int W   = 8;
    localparam int H   = 8;
    localparam int R   = 3;
    localparam int D   = 7;
    localparam int NC  = W - 2 * R;
    localparam int NW  = NC * (H - 2 * R);
    localparam int TOT = W * H;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    fast_window_scheduler_if #(.WIDTH(W), .HEIGHT(H)) bus ();

    fast_window_scheduler #(.WIDTH(W), .HEIGHT(H), .RADIUS(R), .DEPTH(D)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    typedef struct {
        int due;
        int row;
        int col;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    int prod_m = 0, win_m = 0, due_m = 0, fd_due = -1;
    bit fin_m = 0, pend_m = 0, err_m = 0, started_m = 0, clear_m = 0, frame_over = 0;
    int stall_acc = 0;

    function automatic int row_of(int idx);
        return R + idx / NC;
    endfunction

    function automatic int col_of(int idx);
        return R + idx % NC;
    endfunction

    function automatic int need_of(int idx);
        return (row_of(idx) + R) * W + col_of(idx) + R + 1;
    endfunction

    function automatic bit stall_m();
        int i;
        i = (win_m < NW) ? win_m : NW - 1;
        return prod_m >= (row_of(i) - R) * W + D * W;
    endfunction

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        prod_m = 0; win_m = 0; fin_m = 0; pend_m = 0; started_m = 0;
        clear_m = 0; err_m = 0; fd_due = -1; stall_acc = 0;
        exp_q.delete();
    endtask

    // effect of one clock edge with the given inputs on the reference model
    task automatic model_update(bit s, bit gd, bit fd);
        bit st, busy;
        st   = stall_m();
        busy = pend_m && (cyc >= due_m + 2);
        if (s && (st || prod_m == TOT)) err_m = 1;
        if (fd && !busy) err_m = 1;
        if (clear_m) begin
            prod_m = 0; fin_m = 0; win_m = 0; pend_m = 0;
            started_m = 0; clear_m = 0; frame_over = 1;
            return;
        end
        if (s) begin
            started_m = 1;
            if (prod_m < TOT) prod_m++;
        end
        if (gd) fin_m = 1;
        if (fd && busy) begin
            pend_m = 0;
            win_m++;
            if (win_m == NW) begin
                clear_m = 1;
                fd_due  = cyc;
            end
        end
        if (started_m && !pend_m && !clear_m && win_m < NW &&
            (prod_m >= need_of(win_m) || fin_m)) begin
            exp_q.push_back('{due: cyc + 1, row: row_of(win_m), col: col_of(win_m)});
            pend_m = 1;
            due_m  = cyc + 1;
        end
    endtask

    task automatic step(bit s, bit gd, bit fd);
        @(negedge clk);
        bus.gaus_sample_flag = s;
        bus.gaus_done        = gd;
        bus.fast_done_flag   = fd;
        @(posedge clk);
        cyc++;
        model_update(s, gd, fd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        bus.gaus_sample_flag = 1'b0;
        bus.gaus_done        = 1'b0;
        bus.fast_done_flag   = 1'b0;
        n_rst = 1'b0;
        #1;
        check("rst_fast_start", int'(bus.fast_start), 0);
        check("rst_fast_row",   int'(bus.fast_row),   0);
        check("rst_fast_col",   int'(bus.fast_col),   0);
        check("rst_gaus_stall", int'(bus.gaus_stall), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_err",        int'(bus.err),        0);
        model_reset();
        @(posedge clk); cyc++;
        @(posedge clk); cyc++;
        #2 n_rst = 1'b1;
    endtask

    // gd_at < 0: no gaus_done; gd_same: gaus_done rides on sample number gd_at,
    // otherwise it is issued alone once gd_at samples are out
    task automatic run_frame(int nsamp, int gd_at, bit gd_same, bit violate,
                             int rate, int dmax, bit stray, bit abort);
        int sent;
        int dly;
        int budget;
        bit gd_sent;
        bit s, gd, fd;
        sent = 0; budget = 0; frame_over = 0;
        gd_sent = (gd_at < 0);
        if (stray) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b1, 1'b0, 1'b0);
            sent = 1;
            step(1'b0, 1'b0, 1'b1);
        end
        dly = $urandom_range(dmax, 0);
        while (!frame_over && budget < 3000) begin
            if (abort && pend_m && cyc >= due_m + 1) begin
                do_reset();
                return;
            end
            s = (sent < nsamp) && !clear_m && (violate || !stall_m()) &&
                ($urandom_range(99, 0) < rate);
            gd = 1'b0;
            if (!gd_sent) begin
                if (gd_same) gd = s && (sent + 1 == gd_at);
                else if (sent >= gd_at) begin
                    gd = 1'b1;
                    s  = 1'b0;
                end
            end
            fd = 1'b0;
            if (pend_m && cyc >= due_m + 1) begin
                if (dly == 0) begin
                    fd  = 1'b1;
                    dly = $urandom_range(dmax, 0);
                end else begin
                    dly--;
                end
            end
            step(s, gd, fd);
            if (s) sent++;
            if (gd) gd_sent = 1'b1;
            budget++;
        end
        check("frame_complete", int'(frame_over), 1);
    endtask

    // monitor: pops expected launches and compares every observable output
    always @(negedge clk) begin
        bit due_now;
        due_now = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        check("fast_start", int'(bus.fast_start), int'(due_now));
        if (bus.fast_start && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("start_cycle", cyc, mon_e.due);
            check("fast_row", int'(bus.fast_row), mon_e.row);
            check("fast_col", int'(bus.fast_col), mon_e.col);
        end else if (due_now) begin
            void'(exp_q.pop_front());
        end
        check("frame_done", int'(bus.frame_done), int'(fd_due == cyc));
        check("gaus_stall", int'(bus.gaus_stall), int'(stall_m()));
        check("err", int'(bus.err), int'(err_m));
`ifdef FAST_PERF_CNT_EN
        check("stall_cycles", int'(bus.stall_cycles), stall_acc);
        if (fd_due == cyc) stall_acc = 0;
        else if (stall_m()) stall_acc++;
`endif
    end

    initial begin
        int n, gd_at;
        bit gd_same;
        bus.gaus_sample_flag = 1'b0;
        bus.gaus_done        = 1'b0;
        bus.fast_done_flag   = 1'b0;
        do_reset();
        // full-speed frame, gaus_done on the last sample, prompt dones
        run_frame(64, 64, 1'b1, 1'b0, 100, 0, 1'b0, 1'b0);
        // 40 samples then gaus_done alone releases every window
        run_frame(40, 40, 1'b0, 1'b0, 100, 1, 1'b0, 1'b0);
        // protocol abuse: stray dones, samples under stall, 65th sample
        run_frame(65, -1, 1'b0, 1'b1, 100, 3, 1'b1, 1'b0);
        // reset while a window is outstanding, then a clean frame
        run_frame(64, -1, 1'b0, 1'b0, 100, 4, 1'b0, 1'b1);
        run_frame(64, 64, 1'b1, 1'b0, 100, 0, 1'b0, 1'b0);
        for (int f = 0; f < 8; f++) begin
            n       = (f % 2 == 0) ? 64 : int'($urandom_range(63, 1));
            gd_same = 1'($urandom_range(1, 0));
            gd_at   = (n == 64 && f % 4 == 0) ? -1 : n;
            run_frame(n, gd_at, gd_same, 1'b0, int'($urandom_range(100, 30)),
                      int'($urandom_range(6, 0)), 1'b0, 1'b0);
        end
        repeat (5) step(1'b0, 1'b0, 1'b0);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fast_window_scheduler.md
Name: fast_window_scheduler

Overview:
- Successor to the single-counter FAST controller.
- Tracks the raster position of Gaussian output samples and FAST window completions for a parametrised frame and window radius.
- Issues one `fast_start` per valid (non-border) FAST centre, with its row and column, once all window samples exist.
- Backpressures the Gaussian stage when the line buffer would overflow, and signals end of frame.

Parameters:
- WIDTH, 16, image columns (≥ 2*RADIUS+1).
- HEIGHT, 16, image rows (≥ 2*RADIUS+1).
- RADIUS, 3, FAST circle radius; window is (2*RADIUS+1) square.
- DEPTH, 7, line-buffer rows (≥ 2*RADIUS+1).

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- gaus_sample_flag  in  1  one Gaussian sample written this cycle (raster order)
- gaus_done  in  1  Gaussian frame complete; may coincide with last sample
- fast_done_flag  in  1  FAST engine finished current window
- gaus_stall  out  1  producer must not assert gaus_sample_flag
- fast_start  out  1  one-cycle pulse, launch FAST on window
- fast_row  out  clog2(HEIGHT)  centre row, valid while fast_start/BUSY
- fast_col  out  clog2(WIDTH)  centre column, valid while fast_start/BUSY
- frame_done  out  1  one-cycle pulse after last window done
- err  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0; `produced`=0; centre=(RADIUS,RADIUS); `gaus_fin`=0; state IDLE. Reset is asynchronous at any time, mid-frame included, and abandons the frame.
- `produced`: width clog2(WIDTH*HEIGHT+1). Increments on gaus_sample_flag; saturates at WIDTH*HEIGHT.
- A sample arriving when `produced`==WIDTH*HEIGHT sets err and is otherwise ignored.
- A sample arriving while gaus_stall=1 sets err and is still counted.
- gaus_done sets `gaus_fin`. gaus_done with gaus_sample_flag in the same cycle counts the sample first.
- need(r,c) = (r+RADIUS)*WIDTH + (c+RADIUS) + 1. The window for centre (r,c) is ready when produced ≥ need(r,c) or `gaus_fin`=1.
- gaus_stall = (produced − (r−RADIUS)*WIDTH) ≥ DEPTH*WIDTH. It is combinational on registered state and uses the current centre row r.
- States:
  - IDLE: goes to WAIT on the first gaus_sample_flag (that sample is counted).
  - WAIT: when ready, go to START.
  - START: fast_start=1 for exactly one cycle; fast_row/fast_col hold the centre; go to BUSY. Latency is one cycle from ready becoming true to the fast_start pulse.
  - BUSY: on fast_done_flag, advance the centre in raster order over cols RADIUS..WIDTH-1-RADIUS and rows RADIUS..HEIGHT-1-RADIUS. If the done window was the last one (HEIGHT-1-RADIUS, WIDTH-1-RADIUS), go to DONE; else go to WAIT.
  - DONE: frame_done=1 for one cycle; clear produced, gaus_fin and centre; go to IDLE. err is not cleared.
- fast_done_flag outside BUSY: set err, otherwise ignored.
- gaus_sample_flag and fast_done_flag in the same cycle: both take effect. Stall uses the updated state the next cycle.
- Only one window is outstanding at a time. fast_row/fast_col hold their value from START until the advance.
- Frames end only on the last window done. gaus_done before all samples arrive releases all remaining windows, which are processed in order.

Optional Feature:
- Macro FAST_PERF_CNT_EN.
- When defined, adds outputs stall_cycles (32-bit) and wait_cycles (32-bit).
  - stall_cycles counts cycles with gaus_stall=1.
  - wait_cycles counts cycles in WAIT.
  - Both saturate at all-ones, clear on reset and on entering IDLE from DONE, and hold their value through DONE.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
All scenarios use WIDTH=8, HEIGHT=8, RADIUS=3, DEPTH=7.
- Reset, then 54 sample pulses → no fast_start. 55th pulse → fast_start exactly one cycle later, with fast_row=3, fast_col=3.
- Continue to 56 samples without done → gaus_stall=1. Pulse fast_done_flag → next fast_start has (3,4). After its done, centre is (4,3), gaus_stall drops, and fast_start waits for produced ≥ 63.
- Full frame of 64 samples with gaus_done on the last sample and 4 prompt done pulses → centres (3,3), (3,4), (4,3), (4,4), then one frame_done pulse, state IDLE, err=0.
- 40 samples then gaus_done alone → all 4 windows launched back-to-back, one per done pulse, then frame_done.
- fast_done_flag in WAIT, sample during stall, and a 65th sample → err=1 and stays 1 through frame_done. Done and sample in the same cycle → both counted.
- Assert n_rst mid-BUSY → outputs 0 immediately. A following frame restarts at (3,3). With FAST_PERF_CNT_EN defined, stall_cycles equals the number of gaus_stall-high cycles observed.
